// File: rtl/trap_sequencer_if.sv
// ---------------------------------------------------------------------------
// trap_sequencer_if
//
// Purpose:
//   Bundles the signals exchanged between the single-cycle core's control
//   path and the machine-mode trap sequencer. The core side (master) drives
//   the decoded instruction information and CSR access. The sequencer side
//   (slave) returns CSR read data and the stall/kill/redirect controls.
//
// Signal summary:
//   instr_valid     core -> seq   current instruction is real (not a bubble)
//   pc[31:0]        core -> seq   PC of the current instruction
//   int_cause[1:0]  core -> seq   0 none, 1 illegal, 2 ecall, 3 illegal
//   mret            core -> seq   current instruction is mret
//   ext_int         core -> seq   level-sensitive external interrupt request
//   csr_addr[11:0]  core -> seq   CSR access address
//   csr_we          core -> seq   CSR write strobe
//   csr_wdata[31:0] core -> seq   CSR write data
//   csr_rdata[31:0] seq -> core   CSR read data, combinational from csr_addr
//   stall           seq -> core   hold PC/fetch, ignore control unit outputs
//   kill            seq -> core   suppress RegWrite/MemRW of current instr
//   redirect_valid  seq -> core   load PC from redirect_pc this cycle
//   redirect_pc     seq -> core   next PC target
// ---------------------------------------------------------------------------
interface trap_sequencer_if;

    logic        instr_valid;
    logic [31:0] pc;
    logic [1:0]  int_cause;
    logic        mret;
    logic        ext_int;
    logic [11:0] csr_addr;
    logic        csr_we;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        stall;
    logic        kill;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    // Core / control-unit side
    modport master (
        output instr_valid,
        output pc,
        output int_cause,
        output mret,
        output ext_int,
        output csr_addr,
        output csr_we,
        output csr_wdata,
        input  csr_rdata,
        input  stall,
        input  kill,
        input  redirect_valid,
        input  redirect_pc
    );

    // Trap sequencer side
    modport slave (
        input  instr_valid,
        input  pc,
        input  int_cause,
        input  mret,
        input  ext_int,
        input  csr_addr,
        input  csr_we,
        input  csr_wdata,
        output csr_rdata,
        output stall,
        output kill,
        output redirect_valid,
        output redirect_pc
    );

endinterface

// File: rtl/trap_sequencer.sv
// ---------------------------------------------------------------------------
// trap_sequencer
//
// Purpose:
//   Machine-mode trap/return sequencer that sits beside the single-cycle
//   control unit. It owns mstatus (MIE/MPIE), mtvec, mepc and mcause, detects
//   exceptions, external interrupts and mret, and runs a four-cycle trap entry
//   sequence:
//     IDLE (detect) -> SAVE (mepc) -> CAUSE (mcause/mstatus) -> REDIRECT
//   During the sequence the core is stalled and the trapping instruction's
//   side effects are killed; the REDIRECT cycle sends the PC to the handler.
//   mret is handled in a single IDLE cycle by redirecting to mepc.
//
// Parameters:
//   MTVEC_RESET    mtvec value loaded on reset
//   EXT_INT_CODE   mcause[30:0] used for the external interrupt
//
// Ports:
//   clk   core clock, all state updates on the rising edge
//   rst   synchronous, active-high reset; also forces stall/kill/redirect low
//   bus   trap_sequencer_if.slave (see the interface file for the signals)
// ---------------------------------------------------------------------------
module trap_sequencer #(
    parameter logic [31:0] MTVEC_RESET  = 32'h0000_0100,
    parameter logic [30:0] EXT_INT_CODE = 31'd11
) (
    input  logic             clk,
    input  logic             rst,
    trap_sequencer_if.slave  bus
);

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [31:0] CODE_ILLEGAL = 32'd2;
    localparam logic [31:0] CODE_ECALL   = 32'd11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SAVE     = 2'd1,
        CAUSE    = 2'd2,
        REDIRECT = 2'd3
    } state_e;

    state_e      state_q, state_d;

    logic        mie_q,     mie_d;
    logic        mpie_q,    mpie_d;
    logic [31:0] mtvec_q,   mtvec_d;
    logic [31:0] mepc_q,    mepc_d;
    logic [31:0] mcause_q,  mcause_d;
    logic [31:0] trapPc_q,  trapPc_d;
    logic [31:0] trapCode_q, trapCode_d;

    logic        idleValid;
    logic        excReq;
    logic        intReq;
    logic        trapTake;
    logic        retTake;
    logic        csrWrite;
    logic [31:0] trapCode;

    logic        stallOut;
    logic        killOut;
    logic        redirValidOut;
    logic [31:0] redirPcOut;
    logic [31:0] rdataOut;

    // Trap detection only looks at real instructions while idle. Exceptions
    // outrank the interrupt, and either one outranks mret, so an mret that
    // also raises an exception is treated purely as a trap.
    assign idleValid = (state_q == IDLE) && bus.instr_valid;
    assign excReq    = idleValid && (bus.int_cause != 2'd0);
    assign intReq    = idleValid && bus.ext_int && mie_q;
    assign trapTake  = excReq || intReq;
    assign retTake   = idleValid && !trapTake && bus.mret;

    // Software CSR writes are only honoured in IDLE and are dropped in the
    // detect cycle so the trapping instruction cannot alter the trap CSRs.
    assign csrWrite  = (state_q == IDLE) && bus.csr_we && !trapTake;

    // Cause code captured in the detect cycle: encoding 3 of int_cause is
    // folded into the illegal-instruction code.
    always_comb begin
        trapCode = {1'b1, EXT_INT_CODE};
        if (excReq) begin
            trapCode = (bus.int_cause == 2'd2) ? CODE_ECALL : CODE_ILLEGAL;
        end
    end

    // FSM state register. Reset in any state returns to IDLE, which abandons
    // whatever part of a trap sequence was in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic. Once a trap is detected the sequence always runs
    // to completion; nothing but reset can interrupt it.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (trapTake) state_d = SAVE;
            SAVE:     state_d = CAUSE;
            CAUSE:    state_d = REDIRECT;
            REDIRECT: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // FSM output decode. Controls are combinational from state and inputs;
    // reset forces them low so a sequence caught mid-flight never redirects.
    // redirect_pc is held at zero whenever no redirect is requested.
    always_comb begin
        stallOut      = 1'b0;
        killOut       = 1'b0;
        redirValidOut = 1'b0;
        redirPcOut    = 32'h0;
        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    if (trapTake) begin
                        stallOut = 1'b1;
                        killOut  = 1'b1;
                    end else if (retTake) begin
                        redirValidOut = 1'b1;
                        redirPcOut    = mepc_q;
                    end
                end
                SAVE, CAUSE: begin
                    stallOut = 1'b1;
                end
                REDIRECT: begin
                    redirValidOut = 1'b1;
                    redirPcOut    = {mtvec_q[31:2], 2'b00};
                end
                default: begin
                    stallOut = 1'b0;
                end
            endcase
        end
    end

    // CSR and trap-latch next-state logic. Software writes are applied first;
    // the hardware updates (mret, SAVE, CAUSE) follow so that when both touch
    // mstatus in the same cycle the mret update wins. The SAVE and CAUSE
    // updates can never collide with a software write because writes are
    // only accepted in IDLE.
    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtvec_d    = mtvec_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        trapPc_d   = trapPc_q;
        trapCode_d = trapCode_q;

        if (csrWrite) begin
            unique case (bus.csr_addr)
                CSR_MSTATUS: begin
                    mie_d  = bus.csr_wdata[3];
                    mpie_d = bus.csr_wdata[7];
                end
                CSR_MTVEC:  mtvec_d  = bus.csr_wdata;
                CSR_MEPC:   mepc_d   = {bus.csr_wdata[31:2], 2'b00};
                CSR_MCAUSE: mcause_d = bus.csr_wdata;
                default:    mtvec_d  = mtvec_q;
            endcase
        end

        if (retTake) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end

        if (trapTake) begin
            trapPc_d   = bus.pc;
            trapCode_d = trapCode;
        end

        if (state_q == SAVE) begin
            mepc_d = {trapPc_q[31:2], 2'b00};
        end

        if (state_q == CAUSE) begin
            mcause_d = trapCode_q;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end
    end

    // CSR and trap-latch registers. Reset discards any partially applied
    // trap entry along with the software-visible CSR contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= MTVEC_RESET;
            mepc_q     <= 32'h0;
            mcause_q   <= 32'h0;
            trapPc_q   <= 32'h0;
            trapCode_q <= 32'h0;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtvec_q    <= mtvec_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            trapPc_q   <= trapPc_d;
            trapCode_q <= trapCode_d;
        end
    end

    // CSR read mux. mstatus exposes only MIE (bit 3) and MPIE (bit 7);
    // unimplemented addresses read as zero.
    always_comb begin
        rdataOut = 32'h0;
        unique case (bus.csr_addr)
            CSR_MSTATUS: rdataOut = {24'h0, mpie_q, 3'b000, mie_q, 3'b000};
            CSR_MTVEC:   rdataOut = mtvec_q;
            CSR_MEPC:    rdataOut = mepc_q;
            CSR_MCAUSE:  rdataOut = mcause_q;
            default:     rdataOut = 32'h0;
        endcase
    end

    assign bus.stall          = stallOut;
    assign bus.kill           = killOut;
    assign bus.redirect_valid = redirValidOut;
    assign bus.redirect_pc    = redirPcOut;
    assign bus.csr_rdata      = rdataOut;

endmodule

// File: tb/tb_trap_sequencer.sv
// ---------------------------------------------------------------------------
// tb_trap_sequencer
//
// Purpose:
//   Self-checking bench for trap_sequencer. A directed vector table walks the
//   trap entry, mret, interrupt masking, CSR write filtering and mid-sequence
//   reset scenarios; a randomized phase then compares every cycle against a
//   behavioural model that tracks the architectural CSRs and the position in
//   the trap timeline.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_trap_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    trap_sequencer_if bus ();

    trap_sequencer #(
        .MTVEC_RESET  (32'h0000_0100),
        .EXT_INT_CODE (31'd11)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic        rst;
        logic        valid;
        logic [31:0] pc;
        logic [1:0]  cause;
        logic        mret;
        logic        ext;
        logic [11:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic        eStall;
        logic        eKill;
        logic        eRv;
        logic [31:0] eRpc;
        logic [31:0] eRdata;
    } vec_t;

    vec_t vectors[$];

    // Reference model state: architectural CSRs plus how many cycles have
    // elapsed since a trap was detected (0 means no trap in progress).
    logic        mMie, mMpie;
    logic [31:0] mMtvec, mMepc, mMcause;
    logic [31:0] pendPc, pendCode;
    int          age;

    function automatic vec_t mk(
        input logic rs, input logic va, input logic [31:0] p, input logic [1:0] c,
        input logic mr, input logic ex, input logic [11:0] a, input logic w,
        input logic [31:0] wd, input logic s, input logic k, input logic rv,
        input logic [31:0] rpc, input logic [31:0] rd);
        vec_t v;
        v.rst = rs; v.valid = va; v.pc = p; v.cause = c; v.mret = mr; v.ext = ex;
        v.addr = a; v.we = w; v.wdata = wd; v.eStall = s; v.eKill = k;
        v.eRv = rv; v.eRpc = rpc; v.eRdata = rd;
        return v;
    endfunction

    // Drive one cycle's worth of inputs onto the interface
    task automatic applyStimulus(input vec_t v);
        rst             = v.rst;
        bus.instr_valid = v.valid;
        bus.pc          = v.pc;
        bus.int_cause   = v.cause;
        bus.mret        = v.mret;
        bus.ext_int     = v.ext;
        bus.csr_addr    = v.addr;
        bus.csr_we      = v.we;
        bus.csr_wdata   = v.wdata;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input vec_t e);
        checkOutput({tag, " stall"},    {31'h0, bus.stall},          {31'h0, e.eStall});
        checkOutput({tag, " kill"},     {31'h0, bus.kill},           {31'h0, e.eKill});
        checkOutput({tag, " redir_v"},  {31'h0, bus.redirect_valid}, {31'h0, e.eRv});
        checkOutput({tag, " redir_pc"}, bus.redirect_pc,             e.eRpc);
        checkOutput({tag, " rdata"},    bus.csr_rdata,               e.eRdata);
    endtask

    function automatic logic [31:0] modelRead(input logic [11:0] a);
        case (a)
            12'h300: return {24'h0, mMpie, 3'b000, mMie, 3'b000};
            12'h305: return mMtvec;
            12'h341: return mMepc;
            12'h342: return mMcause;
            default: return 32'h0;
        endcase
    endfunction

    task automatic modelReset();
        mMie = 1'b0; mMpie = 1'b0; mMtvec = 32'h100; mMepc = 32'h0; mMcause = 32'h0;
        pendPc = 32'h0; pendCode = 32'h0; age = 0;
    endtask

    // Expected outputs for this cycle plus the architectural effect at the
    // next clock edge, derived directly from the trap/return rules.
    task automatic modelStep(input vec_t v, output vec_t e);
        logic exc, irq, take, ret;
        e = v;
        e.eRdata = modelRead(v.addr);
        e.eStall = 1'b0; e.eKill = 1'b0; e.eRv = 1'b0; e.eRpc = 32'h0;
        if (v.rst) begin
            modelReset();
        end else if (age == 0) begin
            exc  = v.valid && (v.cause != 2'd0);
            irq  = v.valid && v.ext && mMie;
            take = exc || irq;
            ret  = v.valid && !take && v.mret;
            if (take) begin
                e.eStall = 1'b1;
                e.eKill  = 1'b1;
                pendPc   = v.pc;
                pendCode = exc ? ((v.cause == 2'd2) ? 32'd11 : 32'd2) : 32'h8000_000B;
                age      = 1;
            end else begin
                if (ret) begin
                    e.eRv  = 1'b1;
                    e.eRpc = mMepc;
                end
                if (v.we) begin
                    case (v.addr)
                        12'h300: if (!ret) begin mMie = v.wdata[3]; mMpie = v.wdata[7]; end
                        12'h305: mMtvec  = v.wdata;
                        12'h341: mMepc   = v.wdata & 32'hFFFF_FFFC;
                        12'h342: mMcause = v.wdata;
                        default: ;
                    endcase
                end
                if (ret) begin
                    mMie  = mMpie;
                    mMpie = 1'b1;
                end
            end
        end else if (age == 1) begin
            e.eStall = 1'b1;
            mMepc    = pendPc & 32'hFFFF_FFFC;
            age      = 2;
        end else if (age == 2) begin
            e.eStall = 1'b1;
            mMcause  = pendCode;
            mMpie    = mMie;
            mMie     = 1'b0;
            age      = 3;
        end else begin
            e.eRv  = 1'b1;
            e.eRpc = mMtvec & 32'hFFFF_FFFC;
            age    = 0;
        end
    endtask

    // Main test: reset, directed table, then randomized model comparison
    initial begin
        vec_t v, e;

        // rst valid pc cause mret ext addr we wdata | stall kill rv rpc rdata
        vectors.push_back(mk(1,1,32'h40,2,0,0,12'h305,0,0,          0,0,0,0,32'h100));
        vectors.push_back(mk(0,0,0,0,0,0,12'h341,0,0,               0,0,0,0,0));
        vectors.push_back(mk(0,0,0,0,0,0,12'h342,0,0,               0,0,0,0,0));
        vectors.push_back(mk(0,0,0,0,0,0,12'h300,1,32'h8,           0,0,0,0,0));
        vectors.push_back(mk(0,0,0,0,0,0,12'h300,0,0,               0,0,0,0,32'h8));
        // ecall at 0x40
        vectors.push_back(mk(0,1,32'h40,2,0,0,12'h305,0,0,          1,1,0,0,32'h100));
        vectors.push_back(mk(0,1,32'h40,2,0,0,12'h305,1,32'hDEAD0000,1,0,0,0,32'h100));
        vectors.push_back(mk(0,1,32'h40,2,0,0,12'h341,0,0,          1,0,0,0,32'h40));
        vectors.push_back(mk(0,0,0,0,0,0,12'h342,0,0,               0,0,1,32'h100,32'd11));
        vectors.push_back(mk(0,0,0,0,0,0,12'h300,0,0,               0,0,0,0,32'h80));
        vectors.push_back(mk(0,0,0,0,0,0,12'h305,0,0,               0,0,0,0,32'h100));
        // illegal + mret in the same cycle
        vectors.push_back(mk(0,1,32'h80,1,1,0,12'h300,0,0,          1,1,0,0,32'h80));
        vectors.push_back(mk(0,0,0,0,0,0,12'h342,0,0,               1,0,0,0,32'd11));
        vectors.push_back(mk(0,0,0,0,0,0,12'h341,0,0,               1,0,0,0,32'h80));
        vectors.push_back(mk(0,0,0,0,0,0,12'h342,0,0,               0,0,1,32'h100,32'd2));
        vectors.push_back(mk(0,0,0,0,0,0,12'h300,0,0,               0,0,0,0,32'h0));
        // ext_int masked, then enabled
        vectors.push_back(mk(0,1,32'h180,0,0,1,12'h300,1,32'h8,     0,0,0,0,32'h0));
        vectors.push_back(mk(0,1,32'h200,0,0,1,12'h300,0,0,         1,1,0,0,32'h8));
        vectors.push_back(mk(0,1,32'h200,0,0,1,12'h342,0,0,         1,0,0,0,32'd2));
        vectors.push_back(mk(0,1,32'h200,0,0,1,12'h341,0,0,         1,0,0,0,32'h200));
        vectors.push_back(mk(0,0,0,0,0,0,12'h342,0,0,               0,0,1,32'h100,32'h8000000B));
        vectors.push_back(mk(0,1,32'h300,0,0,1,12'h300,0,0,         0,0,0,0,32'h80));
        // mret to mepc 0x44
        vectors.push_back(mk(0,0,0,0,0,0,12'h341,1,32'h47,          0,0,0,0,32'h200));
        vectors.push_back(mk(0,1,32'h104,0,1,0,12'h341,0,0,         0,0,1,32'h44,32'h44));
        vectors.push_back(mk(0,0,0,0,0,0,12'h300,0,0,               0,0,0,0,32'h88));
        // csr_we in detect cycle dropped
        vectors.push_back(mk(0,1,32'h50,2,0,0,12'h305,1,32'h400,    1,1,0,0,32'h100));
        vectors.push_back(mk(0,1,32'h50,2,0,0,12'h305,0,0,          1,0,0,0,32'h100));
        vectors.push_back(mk(0,0,0,0,0,0,12'h341,0,0,               1,0,0,0,32'h50));
        vectors.push_back(mk(0,0,0,0,0,0,12'h300,0,0,               0,0,1,32'h100,32'h80));
        // unaligned mtvec
        vectors.push_back(mk(0,0,0,0,0,0,12'h305,1,32'h203,         0,0,0,0,32'h100));
        vectors.push_back(mk(0,0,0,0,0,0,12'h305,0,0,               0,0,0,0,32'h203));
        vectors.push_back(mk(0,1,32'h60,2,0,0,12'h342,0,0,          1,1,0,0,32'd11));
        vectors.push_back(mk(0,0,0,0,0,0,12'h341,0,0,               1,0,0,0,32'h50));
        vectors.push_back(mk(0,0,0,0,0,0,12'h341,0,0,               1,0,0,0,32'h60));
        vectors.push_back(mk(0,0,0,0,0,0,12'h342,0,0,               0,0,1,32'h200,32'd11));
        // reset during CAUSE
        vectors.push_back(mk(0,0,0,0,0,0,12'h300,1,32'h8,           0,0,0,0,32'h0));
        vectors.push_back(mk(0,1,32'h70,2,0,0,12'h300,0,0,          1,1,0,0,32'h8));
        vectors.push_back(mk(0,0,0,0,0,0,12'h300,0,0,               1,0,0,0,32'h8));
        vectors.push_back(mk(1,0,0,0,0,0,12'h341,0,0,               0,0,0,0,32'h70));
        vectors.push_back(mk(0,0,0,0,0,0,12'h341,0,0,               0,0,0,0,32'h0));
        vectors.push_back(mk(0,0,0,0,0,0,12'h300,0,0,               0,0,0,0,32'h0));
        vectors.push_back(mk(0,0,0,0,0,0,12'h305,0,0,               0,0,0,0,32'h100));
        vectors.push_back(mk(0,0,0,0,0,0,12'h342,0,0,               0,0,0,0,32'h0));
        // unimplemented CSR
        vectors.push_back(mk(0,0,0,0,0,0,12'h7C0,1,32'hFF,          0,0,0,0,32'h0));
        vectors.push_back(mk(0,0,0,0,0,0,12'h7C0,0,0,               0,0,0,0,32'h0));
        // int_cause 3 treated as illegal
        vectors.push_back(mk(0,1,32'h90,3,0,0,12'h305,0,0,          1,1,0,0,32'h100));
        vectors.push_back(mk(0,0,0,0,0,0,12'h305,0,0,               1,0,0,0,32'h100));
        vectors.push_back(mk(0,0,0,0,0,0,12'h341,0,0,               1,0,0,0,32'h90));
        vectors.push_back(mk(0,0,0,0,0,0,12'h342,0,0,               0,0,1,32'h100,32'd2));

        applyStimulus(mk(1,0,0,0,0,0,12'h0,0,0, 0,0,0,0,0));
        repeat (2) @(posedge clk);

        $display("[TB] directed table: %0d vectors", vectors.size());
        for (int i = 0; i < vectors.size(); i++) begin
            @(posedge clk);
            #1;
            applyStimulus(vectors[i]);
            #4;
            checkAll($sformatf("vec%0d", i), vectors[i]);
        end

        $display("[TB] randomized phase");
        @(posedge clk);
        #1;
        applyStimulus(mk(1,0,0,0,0,0,12'h0,0,0, 0,0,0,0,0));
        @(posedge clk);
        modelReset();
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            v.rst   = ($urandom_range(0, 299) == 0);
            v.valid = ($urandom_range(0, 3) != 0);
            v.pc    = $urandom() & 32'h0000_FFFC;
            v.cause = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            v.mret  = ($urandom_range(0, 7) == 0);
            v.ext   = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 4))
                0: v.addr = 12'h300;
                1: v.addr = 12'h305;
                2: v.addr = 12'h341;
                3: v.addr = 12'h342;
                default: v.addr = 12'($urandom());
            endcase
            v.we    = ($urandom_range(0, 3) == 0);
            v.wdata = $urandom();
            v.eStall = 1'b0; v.eKill = 1'b0; v.eRv = 1'b0; v.eRpc = 32'h0; v.eRdata = 32'h0;
            applyStimulus(v);
            modelStep(v, e);
            #4;
            checkAll($sformatf("rnd%0d", n), e);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
